fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  UART transmitter draining the byte FIFO on its read side. Pops one word when
//  the FIFO has data, then serialises it 8N1-style (start, DATA_WIDTH data bits
//  LSB first, one stop bit) on tx at a programmable bit period. Sits between the
//  FIFO and the host-facing serial pin.
// PARAMETERS
//  DATA_WIDTH  8   data bits per frame; must match the FIFO word width
//  DIV_WIDTH   16  width of baud_div; bit period = baud_div+1 clk cycles
// PORTS
//  clk         in   1           clock
//  reset       in   1           synchronous, active-high reset
//  enable      in   1           1 = allowed to start new frames
//  baud_div    in   DIV_WIDTH   bit period minus one, in clk cycles
//  fifo_data   in   DATA_WIDTH  FIFO head word (combinational from FIFO)
//  fifo_valid  in   1           FIFO non-empty
//  fifo_latch  out  1           pop strobe to FIFO, one cycle per word
//  tx          out  1           serial output, idle high
//  busy        out  1           1 while a frame is in progress
// BEHAVIOUR
//  - Reset: state IDLE, tx=1, busy=0, fifo_latch=0, counters cleared. Reset
//    mid-frame aborts the frame; tx high on the next edge; popped word lost.
//  - States: IDLE, START, DATA, STOP. busy = (state != IDLE), registered.
//  - Pop point P = (state==IDLE) or (state==STOP and last cycle of stop bit).
//  - fifo_latch = P && enable && fifo_valid, combinational, never two in a row;
//    never asserted when fifo_valid=0.
//  - On the edge ending a pop cycle: fifo_data -> shift reg, baud_div -> div
//    reg, bit counter cleared, state -> START, tx -> 0. baud_div is sampled
//    only here; changes mid-frame take effect next frame.
//  - Each bit lasts div+1 cycles, timed by a DIV_WIDTH down-counter reloaded
//    with div at each bit boundary. div=0 -> one cycle per bit.
//  - START (tx=0, one bit) -> DATA. DATA: tx = shift[0], shift right per bit,
//    DATA_WIDTH bits, then -> STOP. STOP: tx=1 for one bit.
//  - End of STOP: if pop taken -> START directly (back-to-back, no idle gap);
//    else -> IDLE, tx stays 1.
//  - Frame = (DATA_WIDTH+2)*(div+1) cycles, tx low at edge after pop cycle.
//  - enable low mid-frame: current frame completes; no further pops.
//  - fifo_valid dropping mid-frame has no effect on the frame in flight.
//  - tx is a register output (glitch-free pin).
// TESTING
//  1 reset held 3 cycles, fifo_valid=1 -> tx=1, busy=0, fifo_latch=0 throughout.
//  2 div=3, FIFO holds 0xA5, enable=1 -> one fifo_latch pulse; tx = 0,1,0,1,0,
//    0,1,0,1,1 each for 4 cycles (40 total); busy high 40 cycles then low.
//  3 div=3, FIFO holds 0x00,0xFF -> 2 pops 40 cycles apart; second start bit
//    immediately follows first stop bit; 80 cycles frame-to-frame, no gap.
//  4 enable=0, fifo_valid=1 for 50 cycles -> no fifo_latch, tx=1; raise enable
//    -> fifo_latch same cycle, tx low next edge.
//  5 div=0, byte 0x3C -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1; reset at cycle 5
//    of a div=3 frame -> tx=1 next edge, state IDLE, no extra pop during reset.
//  6 change baud_div 3->7 mid-frame -> current frame keeps 4-cycle bits; next
//    frame uses 8-cycle bits (80 cycles).

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a FIFO read port and shifts them out
// as start bit, DATA_WIDTH data bits (LSB first) and one stop bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_valid,
  output logic                  fifo_latch,
  output logic                  tx,
  output logic                  busy
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic [DIV_WIDTH-1:0]  div_q, div_nxt;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_nxt;
  logic [BIT_CNT_W-1:0]  bit_q, bit_nxt;
  logic                  tx_nxt;
  logic                  bit_end;
  logic                  pop_point;

  assign bit_end   = (cnt_q == '0);
  assign pop_point = (state == IDLE) || ((state == STOP) && bit_end);
  // Gated by reset so a held reset never drains the FIFO.
  assign fifo_latch = pop_point && enable && fifo_valid && !reset;

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    div_nxt   = div_q;
    cnt_nxt   = cnt_q;
    bit_nxt   = bit_q;
    tx_nxt    = tx;
    if (fifo_latch) begin
      shift_nxt = fifo_data;
      div_nxt   = baud_div;
      cnt_nxt   = baud_div;
      bit_nxt   = '0;
      state_nxt = START;
      tx_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_nxt = 1'b1;
        end
        START: begin
          if (bit_end) begin
            state_nxt = DATA;
            cnt_nxt   = div_q;
            tx_nxt    = shift_q[0];
          end else begin
            cnt_nxt = cnt_q - DIV_WIDTH'(1);
          end
        end
        DATA: begin
          // tx is registered, so the next bit is taken from shift_q[1] before the shift lands.
          if (bit_end) begin
            cnt_nxt   = div_q;
            shift_nxt = shift_q >> 1;
            bit_nxt   = bit_q + BIT_CNT_W'(1);
            if (bit_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end else begin
              tx_nxt = shift_q[1];
            end
          end else begin
            cnt_nxt = cnt_q - DIV_WIDTH'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end else begin
            cnt_nxt = cnt_q - DIV_WIDTH'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift_q <= shift_nxt;
      div_q   <= div_nxt;
      cnt_q   <= cnt_nxt;
      bit_q   <= bit_nxt;
      tx      <= tx_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a small queue models the FIFO, and frames
// are checked cycle by cycle against hand-derived serial bit patterns.
module tb_fifo_uart_tx;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] baud_div;
  logic [7:0]  fifo_data;
  logic        fifo_valid;
  logic        fifo_latch;
  logic        tx;
  logic        busy;

  logic [7:0]  fifoQ[$];
  int          popCount;
  int          numCompared;
  int          numMismatched;
  logic        popNow;

  fifo_uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .baud_div   (baud_div),
    .fifo_data  (fifo_data),
    .fifo_valid (fifo_valid),
    .fifo_latch (fifo_latch),
    .tx         (tx),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic refreshFifo();
    fifo_valid = (fifoQ.size() != 0);
    fifo_data  = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
  endtask

  // FIFO model: the pop strobe is sampled at the edge, the head advances just after.
  always @(posedge clk) begin
    popNow = fifo_latch;
    #1;
    if (popNow && fifoQ.size() > 0) begin
      void'(fifoQ.pop_front());
      popCount++;
    end
    refreshFifo();
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    fifoQ.push_back(data);
    refreshFifo();
  endtask

  // Called during the pop cycle; checks every cycle of the frame that follows.
  task automatic checkFrame(input string tag, input logic [7:0] data, input int div);
    logic expBit;
    checkOutput({tag, "_latch"}, 32'(fifo_latch), 32'd1);
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      expBit = 1'b0;
      else if (b == 9) expBit = 1'b1;
      else             expBit = data[b-1];
      for (int k = 0; k <= div; k++) begin
        @(negedge clk);
        checkOutput($sformatf("%s_b%0d_c%0d", tag, b, k), 32'(tx), 32'(expBit));
        if (k == 0) checkOutput($sformatf("%s_busy%0d", tag, b), 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic checkIdleAfter(input string tag);
    checkOutput({tag, "_nolatch"}, 32'(fifo_latch), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_tx"}, 32'(tx), 32'd1);
  endtask

  initial begin
    int latchSeen;
    int txLow;
    int popsBefore;
    numCompared   = 0;
    numMismatched = 0;
    popCount      = 0;
    reset         = 1'b1;
    enable        = 1'b1;
    baud_div      = 16'd3;
    refreshFifo();
    applyStimulus(8'hA5);

    // Reset held with data available: nothing may move.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_tx", 32'(tx), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_latch", 32'(fifo_latch), 32'd0);
    end
    reset = 1'b0;
    #1;
    checkFrame("a5", 8'hA5, 3);
    checkIdleAfter("a5_end");
    checkOutput("pops_a5", 32'(popCount), 32'd1);

    // Back-to-back frames: the second pop lands in the first stop bit's last cycle.
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    #1;
    checkFrame("b2b0", 8'h00, 3);
    checkFrame("b2b1", 8'hFF, 3);
    checkIdleAfter("b2b_end");
    checkOutput("pops_b2b", 32'(popCount), 32'd3);

    // Disabled: data waits, line stays idle.
    enable = 1'b0;
    applyStimulus(8'h5A);
    latchSeen = 0;
    txLow     = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_latch) latchSeen++;
      if (!tx) txLow++;
    end
    checkOutput("dis_latch", 32'(latchSeen), 32'd0);
    checkOutput("dis_txlow", 32'(txLow), 32'd0);
    checkOutput("pops_dis", 32'(popCount), 32'd3);
    enable = 1'b1;
    #1;
    checkFrame("en5a", 8'h5A, 3);
    checkIdleAfter("en5a_end");

    // Fastest rate: one cycle per bit.
    baud_div = 16'd0;
    applyStimulus(8'h3C);
    #1;
    checkFrame("d0_3c", 8'h3C, 0);
    checkIdleAfter("d0_end");
    checkOutput("pops_d0", 32'(popCount), 32'd5);

    // Reset in cycle 5 of a frame; the queued words must survive the reset.
    baud_div = 16'd3;
    applyStimulus(8'h81);
    applyStimulus(8'h42);
    applyStimulus(8'h99);
    #1;
    checkOutput("ab_latch", 32'(fifo_latch), 32'd1);
    for (int i = 0; i < 5; i++) @(negedge clk);
    checkOutput("ab_c5_tx", 32'(tx), 32'd1);
    popsBefore = popCount;
    reset = 1'b1;
    #1;
    checkOutput("ab_rst_latch", 32'(fifo_latch), 32'd0);
    @(negedge clk);
    checkOutput("ab_rst_tx", 32'(tx), 32'd1);
    checkOutput("ab_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("ab_rst_latch2", 32'(fifo_latch), 32'd0);
    checkOutput("ab_pops", 32'(popCount - popsBefore), 32'd0);
    checkOutput("ab_qsize", 32'(fifoQ.size()), 32'd2);
    reset = 1'b0;
    #1;

    // Divider change mid-frame only affects the following frame.
    fork
      begin
        repeat (10) @(negedge clk);
        baud_div = 16'd7;
      end
    join_none
    checkFrame("dv42", 8'h42, 3);
    checkFrame("dv99", 8'h99, 7);
    checkIdleAfter("dv_end");
    checkOutput("pops_final", 32'(popCount), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
